// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio_if
// Description : Load/store port bundle shared by the datapath and the
//               memory-mapped UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_mmio_if;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  rd_mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output rd_en, wr_en, rd_mask, addr, wdata,
        input  rdata
    );

    modport slave (
        input  rd_en, wr_en, rd_mask, addr, wdata,
        output rdata
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_mmio
// Description : Memory-mapped 8N1 UART transmitter on the load/store port.
//               Stores to TXDATA queue bytes in a small FIFO; a bit-timing
//               FSM serialises them onto tx. Loads return status/config
//               combinationally. Optional even parity bit is compiled in
//               with the UART_TX_PARITY_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
    parameter logic [31:0] BASE        = 32'h0000_0400,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          tx,
    output logic          tx_empty
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_PW = c_AW + 1;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd4;
    localparam logic       c_PAR       = 1'b1;
`else
    localparam logic       c_PAR       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [c_PW-1:0] r_wptr;
    logic [c_PW-1:0] r_rptr;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic            r_ovf;
    logic [15:0]     r_div;

    logic [2:0]      r_state;
    logic [15:0]     r_timer;
    logic [7:0]      r_shift;
    logic [2:0]      r_bitcnt;
    logic            r_tx;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
    logic            w_par_nxt;
`endif

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic        w_sel;
    logic        w_wr;
    logic        w_wr_txd;
    logic        w_wr_stat;
    logic        w_wr_div;
    logic        w_full;
    logic        w_empty;
    logic        w_busy;
    logic        w_pop;
    logic        w_push;
    logic        w_ovf_set;
    logic [7:0]  w_fifo_head;
    logic [15:0] w_bit_len;
    logic        w_timer_end;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_timer_nxt;
    logic [7:0]  w_shift_nxt;
    logic [2:0]  w_bitcnt_nxt;
    logic        w_tx_nxt;

    logic [31:0] w_reg;
    logic [31:0] w_lane;
    logic [31:0] w_load;
    logic        w_unused;

    assign w_sel     = (bus.addr[31:4] == BASE[31:4]);
    assign w_wr      = bus.wr_en && w_sel;
    assign w_wr_txd  = w_wr && (bus.addr[3:2] == 2'd0);
    assign w_wr_stat = w_wr && (bus.addr[3:2] == 2'd1);
    assign w_wr_div  = w_wr && (bus.addr[3:2] == 2'd2);

    // Extra pointer bit distinguishes full from empty when indices match.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_PW-1] != r_rptr[c_PW-1]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_busy    = (r_state != c_ST_IDLE);

    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign w_push    = w_wr_txd && (!w_full || w_pop);
    assign w_ovf_set = w_wr_txd && w_full && !w_pop;

    assign w_fifo_head = r_mem[r_rptr[c_AW-1:0]];
    // BAUDDIV is never 0, so the reload value never underflows.
    assign w_bit_len   = r_div - 16'd1;
    assign w_timer_end = (r_timer == 16'd0);

    assign tx        = r_tx;
    assign tx_empty  = w_empty && !w_busy;
    assign w_unused  = &{1'b0, bus.wdata[31:16]};

    // FIFO pointers, sticky overflow flag and baud divisor register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_div  <= DEFAULT_DIV;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PW'(1);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_stat && bus.wdata[3]) begin
                r_ovf <= 1'b0;
            end
            if (w_wr_div) begin
                r_div <= (bus.wdata[15:0] == 16'd0) ? 16'd1 : bus.wdata[15:0];
            end
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_AW-1:0]] <= bus.wdata[7:0];
        end
    end

    // Transmit FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_timer  <= 16'd0;
            r_shift  <= 8'd0;
            r_bitcnt <= 3'd0;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_tx     <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    // Transmit FSM next state; each bit reloads the timer from the current BAUDDIV.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_tx_nxt     = r_tx;
        w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nxt    = r_par;
`endif
        case (r_state)
            c_ST_IDLE: begin
                w_tx_nxt = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_head;
                    w_timer_nxt = w_bit_len;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = c_ST_START;
`ifdef UART_TX_PARITY_EN
                    w_par_nxt   = ^w_fifo_head;
`endif
                end
            end
            c_ST_START: begin
                if (w_timer_end) begin
                    w_state_nxt  = c_ST_DATA;
                    w_tx_nxt     = r_shift[0];
                    w_shift_nxt  = {1'b0, r_shift[7:1]};
                    w_bitcnt_nxt = 3'd0;
                    w_timer_nxt  = w_bit_len;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            c_ST_DATA: begin
                if (w_timer_end) begin
                    w_timer_nxt = w_bit_len;
                    if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = c_ST_PARITY;
                        w_tx_nxt    = r_par;
`else
                        w_state_nxt = c_ST_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_tx_nxt     = r_shift[0];
                        w_shift_nxt  = {1'b0, r_shift[7:1]};
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_timer_end) begin
                    w_state_nxt = c_ST_STOP;
                    w_tx_nxt    = 1'b1;
                    w_timer_nxt = w_bit_len;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
`endif
            c_ST_STOP: begin
                if (w_timer_end) begin
                    w_state_nxt = c_ST_IDLE;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - 16'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // Load path: pick the register, shift the addressed lane down, extend.
    always_comb begin
        w_reg = 32'd0;
        case (bus.addr[3:2])
            2'd1:    w_reg = {27'd0, c_PAR, r_ovf, w_busy, w_empty, w_full};
            2'd2:    w_reg = {16'd0, r_div};
            default: w_reg = 32'd0;
        endcase
        w_lane = w_reg >> {bus.addr[1:0], 3'b000};
        case (bus.rd_mask)
            3'b000:  w_load = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load = w_reg;
            3'b100:  w_load = {24'd0, w_lane[7:0]};
            3'b101:  w_load = {16'd0, w_lane[15:0]};
            default: w_load = 32'd0;
        endcase
    end

    assign bus.rdata = (bus.rd_en && w_sel) ? w_load : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_mmio
// Description : Self-checking bench for uart_tx_mmio. A transaction-level
//               FIFO/timeline model predicts register reads and the byte
//               order on tx; a free-running line decoder recovers frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;

    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int   NB   = 11;
    localparam logic PARB = 1'b1;
`else
    localparam int   NB   = 10;
    localparam logic PARB = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  data;
        logic        start_b;
        logic        stop_b;
        logic        par_ok;
        logic        glitch;
        logic [31:0] t;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic tx_empty;

    uart_tx_mmio_if bus ();

    uart_tx_mmio dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .tx       (tx),
        .tx_empty (tx_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0] mq[$];
    logic [7:0] expq[$];
    int         m_div  = 868;
    logic       m_ovf  = 1'b0;
    int         m_free = 0;
    int         mcyc   = 0;

    frame_t rxq[$];
    int     starts = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic m_busy();
        return (mcyc < m_free - 1);
    endfunction

    function automatic logic [31:0] m_status();
        return {27'd0, PARB, m_ovf, m_busy(), (mq.size() == 0), (mq.size() == DEPTH)};
    endfunction

    function automatic logic [31:0] exp_rd(logic [31:0] a, logic [2:0] m);
        logic [31:0] word;
        int b;
        int h;
        int off;
        if (a[31:4] != 28'h000_0040) return 32'd0;
        case (a[3:2])
            2'd1:    word = m_status();
            2'd2:    word = 32'(m_div);
            default: word = 32'd0;
        endcase
        off = int'(a[1:0]);
        b = int'((word >> (8 * off)) & 32'hFF);
        h = int'((word >> (8 * off)) & 32'hFFFF);
        case (m)
            3'b000:  return 32'((b >= 128) ? b - 256 : b);
            3'b001:  return 32'((h >= 32768) ? h - 65536 : h);
            3'b010:  return word;
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge: snapshot driven inputs, advance the model, release strobes.
    task automatic tick();
        logic        wr;
        logic        rs;
        logic [31:0] a;
        logic [31:0] d;
        wr = bus.wr_en;
        rs = reset;
        a  = bus.addr;
        d  = bus.wdata;
        @(posedge clk);
        mcyc++;
        if (rs) begin
            mq.delete();
            expq.delete();
            rxq.delete();
            m_ovf  = 1'b0;
            m_div  = 868;
            m_free = 0;
        end else begin
            if (mq.size() > 0 && mcyc >= m_free) begin
                expq.push_back(mq.pop_front());
                m_free = mcyc + NB * m_div + 1;
            end
            if (wr && a[31:4] == 28'h000_0040) begin
                case (a[3:2])
                    2'd0: begin
                        if (mq.size() < DEPTH) mq.push_back(d[7:0]);
                        else m_ovf = 1'b1;
                    end
                    2'd1: if (d[3]) m_ovf = 1'b0;
                    2'd2: m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
                    default: ;
                endcase
            end
        end
        #1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic st(logic [31:0] a, logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick();
    endtask

    task automatic rd(string tag, logic [31:0] a, logic [2:0] m);
        bus.rd_en   = 1'b1;
        bus.addr    = a;
        bus.rd_mask = m;
        #1;
        check(tag, bus.rdata, exp_rd(a, m));
        bus.rd_en = 1'b0;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_frames(string tag, int n, int budget);
        int k;
        k = 0;
        while (rxq.size() < n && k < budget) begin
            tick();
            k++;
        end
        checks++;
        assert (rxq.size() >= n) else begin
            errors++;
            $error("FAIL %s frames=%0d expected=%0d", tag, rxq.size(), n);
        end
    endtask

    task automatic check_frames(string tag, int n, int gap);
        frame_t     f;
        logic [7:0] e;
        int         prev_t;
        prev_t = 0;
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (rxq.size() > 0 && expq.size() > 0) else begin
                errors++;
                $error("FAIL %s_avail rx=%0d expected=%0d", tag, rxq.size(), expq.size());
            end
            if (rxq.size() == 0 || expq.size() == 0) break;
            f = rxq.pop_front();
            e = expq.pop_front();
            check({tag, "_data"}, 32'(f.data), 32'(e));
            check({tag, "_fmt"}, 32'({f.start_b, f.stop_b, f.par_ok, f.glitch}), 32'(4'b0110));
            if (gap > 0 && i > 0) check({tag, "_gap"}, f.t - 32'(prev_t), 32'(gap));
            prev_t = int'(f.t);
        end
    endtask

    // Line decoder: on each falling edge from idle, sample a whole frame,
    // flagging any level change inside a bit period.
    initial begin : decoder
        logic        prev;
        logic [10:0] bits;
        logic        abort;
        logic        glitch;
        int          d;
        int          dcyc;
        int          t0;
        frame_t      f;
        prev = 1'b1;
        dcyc = 0;
        forever begin
            @(negedge clk);
            dcyc++;
            if (reset !== 1'b1 && prev === 1'b1 && tx === 1'b0) begin
                starts++;
                d      = m_div;
                t0     = dcyc;
                abort  = 1'b0;
                glitch = 1'b0;
                bits   = '0;
                for (int k = 0; k < NB * d; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        dcyc++;
                    end
                    if (reset === 1'b1) begin
                        abort = 1'b1;
                        break;
                    end
                    if (k % d == 0) bits[k / d] = tx;
                    else if (tx !== bits[k / d]) glitch = 1'b1;
                end
                if (!abort) begin
                    f.data    = bits[8:1];
                    f.start_b = bits[0];
                    f.stop_b  = bits[NB - 1];
`ifdef UART_TX_PARITY_EN
                    f.par_ok  = (bits[9] === ^bits[8:1]);
`else
                    f.par_ok  = 1'b1;
`endif
                    f.glitch  = glitch;
                    f.t       = 32'(t0);
                    rxq.push_back(f);
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [2:0]  masks [5];
        logic [31:0] v;
        int          n;
        int          s0;
        masks = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        reset       = 1'b1;
        bus.rd_en   = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_mask = 3'b010;
        bus.addr    = 32'd0;
        bus.wdata   = 32'd0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        rd("rst_status", 32'h404, 3'b010);
        rd("rst_div", 32'h408, 3'b010);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_empty", 32'(tx_empty), 32'd1);
        tick();

        // Single frame at BAUDDIV=4
        st(32'h408, 32'd4);
        st(32'h400, 32'hA5);
        check("e0_tx_high", 32'(tx), 32'd1);
        tick();
        check("e1_tx_low", 32'(tx), 32'd0);
        rd("busy_lb_status", 32'h404, 3'b000);
        rd("busy_lbu_405", 32'h405, 3'b100);
        wait_frames("a5_wait", 1, NB * 4 + 10);
        check_frames("a5", 1, 0);
        ticks(3);
        check("a5_tx_empty", 32'(tx_empty), 32'd1);
        rd("a5_status", 32'h404, 3'b010);

        // Five back-to-back stores fill the FIFO; a sixth overflows
        for (int i = 0; i < 5; i++) st(32'h400, $urandom & 32'hFF);
        rd("full_status", 32'h404, 3'b010);
        st(32'h400, $urandom & 32'hFF);
        rd("ovf_status", 32'h404, 3'b010);
        st(32'h404, 32'h8);
        rd("ovf_clr_status", 32'h404, 3'b010);
        wait_frames("b2b_wait", 5, 5 * (NB * 4 + 1) + 20);
        check_frames("b2b", 5, NB * 4 + 1);
        ticks(3);

        // BAUDDIV write of 0 becomes 1; frame occupies exactly NB cycles
        st(32'h408, 32'd0);
        rd("div_zero", 32'h408, 3'b010);
        st(32'h400, $urandom & 32'hFF);
        tick();
        ticks(NB - 1);
        rd("div1_last_busy", 32'h404, 3'b010);
        check("div1_tx_empty_busy", 32'(tx_empty), 32'(!m_busy() && mq.size() == 0));
        tick();
        rd("div1_idle", 32'h404, 3'b010);
        check("div1_tx_empty_idle", 32'(tx_empty), 32'(!m_busy() && mq.size() == 0));
        wait_frames("div1_wait", 1, 5);
        check_frames("div1", 1, 0);
        ticks(2);

        // Random bursts at small divisors
        for (int r = 0; r < 3; r++) begin
            st(32'h408, 32'($urandom_range(1, 3)));
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) st(32'h400, $urandom & 32'hFF);
            wait_frames("rnd_wait", n, n * (NB * 3 + 1) + 20);
            check_frames("rnd", n, NB * m_div + 1);
            ticks(3);
        end

        // Reset mid-frame with three bytes still queued
        st(32'h408, 32'd4);
        for (int i = 0; i < 4; i++) st(32'h400, $urandom & 32'hFF);
        ticks(15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid_tx", 32'(tx), 32'd1);
        check("rstmid_tx_empty", 32'(tx_empty), 32'd1);
        rd("rstmid_status", 32'h404, 3'b010);
        rd("rstmid_div", 32'h408, 3'b010);
        s0 = starts;
        ticks(200);
        check("rstmid_no_frames", 32'(starts), 32'(s0));
        check("rstmid_rxq", 32'(rxq.size()), 32'd0);
        check("rstmid_tx_idle", 32'(tx), 32'd1);

        // Randomised load lane selection on BAUDDIV
        for (int i = 0; i < 8; i++) begin
            st(32'h408, $urandom & 32'hFFFF);
            v = 32'h408 | 32'($urandom_range(0, 3));
            rd("lane_div", v, masks[$urandom_range(0, 4)]);
            tick();
        end

        // Decode holes and strobe gating
        rd("rd_txdata", 32'h400, 3'b010);
        rd("rd_reserved", 32'h40C, 3'b010);
        tick();
        rd("rd_unselected", 32'h508, 3'b010);
        bus.rd_en = 1'b0;
        bus.addr  = 32'h408;
        #1;
        check("rd_en_low", bus.rdata, 32'd0);
        tick();

        // Simultaneous load and store return pre-edge value
        bus.rd_en   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.addr    = 32'h408;
        bus.rd_mask = 3'b010;
        bus.wdata   = 32'h0000_1234;
        #1;
        check("rdwr_old", bus.rdata, exp_rd(32'h408, 3'b010));
        tick();
        rd("rdwr_new", 32'h408, 3'b010);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
